adc_scan_master: RTL and testbench

Bus-initiator side of the 8-channel ADC conversion handshake (ALE/address, START, EOC, OE, 8-bit data), i.e. the controller end of the interface the `adc_8090` model responds on. It walks an enabled-channel mask, runs one conversion per channel and keeps the latest result per channel in a register bank readable at any time. It lets benches and stand-alone harnesses sample the sensor ADC without the i8048 firmware, and cross-checks `adc_8090` from the opposite side.

---
 rtl/adc_scan_master.sv | 213 +++++++++++++++++++++
 tb/tb_adc_scan_master.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_master.sv
// adc_scan_master
//   Controller side of an 8-channel ADC conversion handshake. It walks the
//   enabled channels in CH_MASK and runs one ALE/START/EOC/OE conversion per
//   channel. The latest result for each channel is kept in a bank that can be
//   read combinationally at any time.
//
// Parameters
//   CH_MASK      channels included in a scan (bit n = channel n)
//   EOC_TIMEOUT  max cycles in WAIT_LO + WAIT_HI before a channel is abandoned
//   OE_HOLD      cycles adc_oe stays high; data is captured on the last one
//
// Ports
//   clk, res_n           clock (rising edge), asynchronous active-low reset
//   run                  level; scans repeat back-to-back while high
//   single               one-cycle request for one scan (accepted in IDLE only)
//   adc_addr/ale/start   channel select, address latch strobe, start strobe
//   adc_oe               ADC output enable
//   adc_eoc, adc_data    end of conversion (low while converting), result
//   rd_ch, rd_data       result bank read port (combinational)
//   res_valid, res_ch    one-cycle pulse and channel for each bank write
//   scan_done            one-cycle pulse after the last enabled channel
//   busy                 high whenever the controller is not idle
//   to_err               sticky per-channel EOC timeout flags
//
// Build option
//   ADC_SCAN_AVG_EN      bank writes store the rounded average of the old and
//                        new value; the first write per channel stores raw data.

module adc_scan_master #(
    parameter logic [7:0]  CH_MASK     = 8'hFF,
    parameter int unsigned EOC_TIMEOUT = 1023,
    parameter int unsigned OE_HOLD     = 2
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       run,
    input  logic       single,
    output logic [2:0] adc_addr,
    output logic       adc_ale,
    output logic       adc_start,
    output logic       adc_oe,
    input  logic       adc_eoc,
    input  logic [7:0] adc_data,
    input  logic [2:0] rd_ch,
    output logic [7:0] rd_data,
    output logic       res_valid,
    output logic [2:0] res_ch,
    output logic       scan_done,
    output logic       busy,
    output logic [7:0] to_err
);

    localparam int unsigned TW = $clog2(EOC_TIMEOUT + 1);
    localparam int unsigned OW = $clog2(OE_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_READ,
        S_NEXT
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    ch, ch_nxt;
    logic [TW-1:0] tcnt;
    logic [OW-1:0] ocnt;
    logic [7:0]    bank [8];
    logic [7:0]    wr_val;

    logic          has_any, has_higher;
    logic [2:0]    ch_lo, ch_hi;
    logic          tmo, rd_last, done_nxt;

    // Lowest enabled channel, and the next enabled channel above the current one.
    always_comb begin
        has_any    = 1'b0;
        has_higher = 1'b0;
        ch_lo      = '0;
        ch_hi      = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (CH_MASK[3'(i)] && !has_any) begin
                has_any = 1'b1;
                ch_lo   = 3'(i);
            end
            if (CH_MASK[3'(i)] && (3'(i) > ch) && !has_higher) begin
                has_higher = 1'b1;
                ch_hi      = 3'(i);
            end
        end
    end

    // tcnt counts wait cycles from 0, so this marks the EOC_TIMEOUT-th wait cycle.
    assign tmo     = (tcnt == TW'(EOC_TIMEOUT - 1));
    assign rd_last = (ocnt == OW'(OE_HOLD - 1));

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if ((run || single) && has_any) begin
                    state_nxt = S_ADDR;
                    ch_nxt    = ch_lo;
                end
            end
            S_ADDR:    state_nxt = S_START;
            S_START:   state_nxt = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!adc_eoc)  state_nxt = S_WAIT_HI;
                else if (tmo)  state_nxt = S_NEXT;
            end
            S_WAIT_HI: begin
                if (adc_eoc)   state_nxt = S_READ;
                else if (tmo)  state_nxt = S_NEXT;
            end
            S_READ: begin
                if (rd_last) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (has_higher) begin
                    state_nxt = S_ADDR;
                    ch_nxt    = ch_hi;
                end else begin
                    done_nxt = 1'b1;
                    if (run) begin
                        state_nxt = S_ADDR;
                        ch_nxt    = ch_lo;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef ADC_SCAN_AVG_EN
    logic [7:0] seeded;
    logic [8:0] avg_sum;

    assign avg_sum = {1'b0, bank[ch]} + {1'b0, adc_data} + 9'd1;
    assign wr_val  = seeded[ch] ? avg_sum[8:1] : adc_data;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)
            seeded <= '0;
        else if (state == S_READ && rd_last)
            seeded[ch] <= 1'b1;
    end
`else
    assign wr_val = adc_data;
`endif

    // Strobes are registered from the next state so each one is high exactly
    // while the FSM sits in the matching state.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= S_IDLE;
            ch        <= '0;
            tcnt      <= '0;
            ocnt      <= '0;
            adc_addr  <= '0;
            adc_ale   <= 1'b0;
            adc_start <= 1'b0;
            adc_oe    <= 1'b0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            scan_done <= 1'b0;
            to_err    <= '0;
            for (int unsigned i = 0; i < 8; i++)
                bank[i] <= '0;
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            adc_ale   <= (state_nxt == S_ADDR);
            adc_start <= (state_nxt == S_START);
            adc_oe    <= (state_nxt == S_READ);
            scan_done <= done_nxt;
            res_valid <= 1'b0;

            if (state_nxt == S_ADDR)
                adc_addr <= ch_nxt;

            if (state == S_START)
                tcnt <= '0;
            else if (state == S_WAIT_LO || state == S_WAIT_HI)
                tcnt <= tcnt + 1'b1;

            if (state == S_READ)
                ocnt <= ocnt + 1'b1;
            else
                ocnt <= '0;

            if ((state == S_WAIT_LO || state == S_WAIT_HI) && state_nxt == S_NEXT)
                to_err[ch] <= 1'b1;

            if (state == S_READ && rd_last) begin
                bank[ch]   <= wr_val;
                to_err[ch] <= 1'b0;
                res_valid  <= 1'b1;
                res_ch     <= ch;
            end
        end
    end

    assign rd_data = bank[rd_ch];
    assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_adc_scan_master.sv
module tb_adc_scan_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res_n, run, single, run_m;
    logic [2:0] rd_ch;

    logic [2:0] adc_addr, res_ch;
    logic       adc_ale, adc_start, adc_oe, res_valid, scan_done, busy;
    logic       adc_eoc = 1'b1;
    logic [7:0] adc_data, rd_data, to_err;

    logic [2:0] adc_addr_m, res_ch_m;
    logic       adc_ale_m, adc_start_m, adc_oe_m, res_valid_m, scan_done_m, busy_m;
    logic       adc_eoc_m = 1'b1;
    logic [7:0] adc_data_m, rd_data_m, to_err_m;

    int checks = 0;
    int errors = 0;

    adc_scan_master #(.CH_MASK(8'hFF), .EOC_TIMEOUT(16), .OE_HOLD(2)) dut (
        .clk(clk), .res_n(res_n), .run(run), .single(single),
        .adc_addr(adc_addr), .adc_ale(adc_ale), .adc_start(adc_start), .adc_oe(adc_oe),
        .adc_eoc(adc_eoc), .adc_data(adc_data), .rd_ch(rd_ch), .rd_data(rd_data),
        .res_valid(res_valid), .res_ch(res_ch), .scan_done(scan_done), .busy(busy),
        .to_err(to_err)
    );

    adc_scan_master #(.CH_MASK(8'b1010_0100), .EOC_TIMEOUT(16), .OE_HOLD(2)) dut_m (
        .clk(clk), .res_n(res_n), .run(run_m), .single(1'b0),
        .adc_addr(adc_addr_m), .adc_ale(adc_ale_m), .adc_start(adc_start_m), .adc_oe(adc_oe_m),
        .adc_eoc(adc_eoc_m), .adc_data(adc_data_m), .rd_ch(3'd0), .rd_data(rd_data_m),
        .res_valid(res_valid_m), .res_ch(res_ch_m), .scan_done(scan_done_m), .busy(busy_m),
        .to_err(to_err_m)
    );

    // ADC model: EOC drops in the START cycle, rises two WAIT_HI cycles later.
    logic [7:0] tbl [8];
    logic [7:0] hang = '0;
    logic [2:0] lat = '0;
    int         cnt = 0;
    int         cnt_m = 0;

    always @(negedge clk) begin
        if (adc_ale) lat = adc_addr;
        if (adc_start) begin
            if (!hang[adc_addr]) begin
                adc_eoc = 1'b0;
                cnt = 3;
            end
        end else if (!adc_eoc) begin
            cnt = cnt - 1;
            if (cnt == 0) adc_eoc = 1'b1;
        end
    end
    assign adc_data = adc_oe ? tbl[lat] : 8'h00;

    always @(negedge clk) begin
        if (adc_start_m) begin
            adc_eoc_m = 1'b0;
            cnt_m = 3;
        end else if (!adc_eoc_m) begin
            cnt_m = cnt_m - 1;
            if (cnt_m == 0) adc_eoc_m = 1'b1;
        end
    end
    assign adc_data_m = adc_oe_m ? 8'h5A : 8'h00;

    task automatic load_table();
        for (int i = 0; i < 8; i++) tbl[i] = 8'h81 + 8'(i);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 res_n = 1'b0;
        @(posedge clk); #1 res_n = 1'b1;
    endtask

    // Drives one single pulse and records activity until busy drops.
    task automatic do_scan(output int n_rv, output int n_done, output int c_first,
                           output int c_last, output int c_done, output int n_oe,
                           output logic [23:0] order, output bit tmo);
        n_rv = 0; n_done = 0; c_first = -1; c_last = -1; c_done = -1; n_oe = 0;
        order = '0; tmo = 1'b1;
        single = 1'b1;
        @(posedge clk); #1 single = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                if (n_rv == 0) c_first = c;
                c_last = c;
                if (n_rv < 8) order[3*n_rv +: 3] = res_ch;
                n_rv++;
            end
            if (adc_oe) n_oe++;
            if (scan_done) begin n_done++; c_done = c; end
            if (!busy) begin tmo = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({adc_ale, adc_start, adc_oe, res_valid, scan_done, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 000000",
                     {adc_ale, adc_start, adc_oe, res_valid, scan_done, busy});
        end
        checks++;
        if (adc_addr !== 3'd0 || to_err !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr_err got addr=%0d to_err=%h want 0/00", adc_addr, to_err);
        end
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i); #1;
            checks++;
            if (rd_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_bank ch%0d got %h want 00", i, rd_data);
            end
        end
        rd_ch = 3'd0;
        @(posedge clk); #1 res_n = 1'b1;
    endtask

    task automatic test_single_scan();
        int n_rv, n_done, c_first, c_last, c_done, n_oe;
        logic [23:0] order, exp_order;
        bit tmo;
        for (int i = 0; i < 8; i++) exp_order[3*i +: 3] = 3'(i);
        do_scan(n_rv, n_done, c_first, c_last, c_done, n_oe, order, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL single_timeout busy never dropped"); end
        checks++;
        if (n_rv != 8 || order !== exp_order) begin
            errors++;
            $display("FAIL single_order got n=%0d order=%h want 8/%h", n_rv, order, exp_order);
        end
        checks++;
        if (n_done != 1 || c_done != 64) begin
            errors++;
            $display("FAIL single_done got n=%0d cyc=%0d want 1/64", n_done, c_done);
        end
        checks++;
        if (c_first != 7 || c_last != 63) begin
            errors++;
            $display("FAIL single_timing got first=%0d last=%0d want 7/63", c_first, c_last);
        end
        checks++;
        if (n_oe != 16) begin
            errors++;
            $display("FAIL single_oe_cycles got %0d want 16", n_oe);
        end
        rd_ch = 3'd5; #1;
        checks++;
        if (rd_data !== 8'h86) begin
            errors++;
            $display("FAIL single_rd5 got %h want 86", rd_data);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        int n_rv, n_done, c_first, c_last, c_done, n_oe;
        logic [23:0] order, exp_order;
        bit tmo;
        int k;
        pulse_reset();
        hang = 8'h08;
        k = 0;
        for (int i = 0; i < 8; i++) if (i != 3) begin exp_order[3*k +: 3] = 3'(i); k++; end
        exp_order[23:21] = 3'd0;
        do_scan(n_rv, n_done, c_first, c_last, c_done, n_oe, order, tmo);
        checks++;
        if (tmo || n_rv != 7 || order !== exp_order || n_done != 1) begin
            errors++;
            $display("FAIL to_scan got tmo=%0d n=%0d order=%h done=%0d want 0/7/%h/1",
                     tmo, n_rv, order, n_done, exp_order);
        end
        checks++;
        if (c_last != 74) begin
            errors++;
            $display("FAIL to_timing got last=%0d want 74", c_last);
        end
        checks++;
        if (to_err !== 8'h08) begin errors++; $display("FAIL to_err got %h want 08", to_err); end
        rd_ch = 3'd3; #1;
        checks++;
        if (rd_data !== 8'h00) begin errors++; $display("FAIL to_bank3 got %h want 00", rd_data); end
        rd_ch = 3'd4; #1;
        checks++;
        if (rd_data !== 8'h85) begin errors++; $display("FAIL to_bank4 got %h want 85", rd_data); end
        hang = 8'h00;
        do_scan(n_rv, n_done, c_first, c_last, c_done, n_oe, order, tmo);
        rd_ch = 3'd3; #1;
        checks++;
        if (tmo || to_err !== 8'h00 || rd_data !== 8'h84) begin
            errors++;
            $display("FAIL to_clear got tmo=%0d to_err=%h bank3=%h want 0/00/84", tmo, to_err, rd_data);
        end
    endtask

    task automatic test_run_mask();
        int n_ale, n_done;
        logic [17:0] seq, exp_seq;
        bit dropped, ok;
        logic [2:0] chs [3];
        chs[0] = 3'd2; chs[1] = 3'd5; chs[2] = 3'd7;
        for (int i = 0; i < 6; i++) exp_seq[3*i +: 3] = chs[i % 3];
        n_ale = 0; n_done = 0; seq = '0; dropped = 1'b0; ok = 1'b0;
        run_m = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (adc_ale_m) begin
                if (n_ale < 6) seq[3*n_ale +: 3] = adc_addr_m;
                n_ale++;
            end
            if (scan_done_m) begin
                n_done++;
                if (!dropped) begin run_m = 1'b0; dropped = 1'b1; end
            end
            if (dropped && !busy_m) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL mask_timeout busy never dropped"); end
        checks++;
        if (n_ale != 6 || seq !== exp_seq) begin
            errors++;
            $display("FAIL mask_seq got n=%0d seq=%h want 6/%h", n_ale, seq, exp_seq);
        end
        checks++;
        if (n_done != 2) begin errors++; $display("FAIL mask_done got %0d want 2", n_done); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int n_done, n_rv;
        seen = 1'b0;
        run = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (adc_ale && adc_addr == 3'd2) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rmid_reach no ALE on ch2"); end
        repeat (3) begin @(posedge clk); #1; end
        res_n = 1'b0; #1;
        checks++;
        if ({adc_ale, adc_start, adc_oe, res_valid, scan_done, busy, adc_addr, to_err} !== '0) begin
            errors++;
            $display("FAIL rmid_outputs got %b want all zero",
                     {adc_ale, adc_start, adc_oe, res_valid, scan_done, busy, adc_addr, to_err});
        end
        @(posedge clk); #1;
        checks++;
        if ({adc_ale, adc_start, adc_oe, busy} !== 4'b0) begin
            errors++;
            $display("FAIL rmid_held got %b want 0000", {adc_ale, adc_start, adc_oe, busy});
        end
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i); #1;
            checks++;
            if (rd_data !== 8'h00) begin
                errors++;
                $display("FAIL rmid_bank ch%0d got %h want 00", i, rd_data);
            end
        end
        res_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (adc_ale) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen || adc_addr !== 3'd0) begin
            errors++;
            $display("FAIL rmid_restart got seen=%0d addr=%0d want 1/0", seen, adc_addr);
        end
        run = 1'b0;
        n_done = 0; n_rv = 0; seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (res_valid) n_rv++;
            if (scan_done) n_done++;
            if (!busy) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen || n_done != 1 || n_rv != 8) begin
            errors++;
            $display("FAIL rmid_rundrop got idle=%0d done=%0d rv=%0d want 1/1/8", seen, n_done, n_rv);
        end
    endtask

    task automatic test_single_busy();
        int n_done;
        bit idle, extra;
        single = 1'b1;
        @(posedge clk); #1 single = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL sbusy_busy got %b want 1", busy); end
        single = 1'b1;
        @(posedge clk); #1 single = 1'b0;
        n_done = 0; idle = 1'b0; extra = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (scan_done) n_done++;
            if (!busy) begin idle = 1'b1; break; end
        end
        repeat (20) begin
            @(posedge clk); #1;
            if (busy || scan_done) extra = 1'b1;
        end
        checks++;
        if (!idle || n_done != 1 || extra) begin
            errors++;
            $display("FAIL sbusy_once got idle=%0d done=%0d extra=%0d want 1/1/0", idle, n_done, extra);
        end
    endtask

    task automatic test_avg();
        int n_rv, n_done, c_first, c_last, c_done, n_oe;
        logic [23:0] order;
        bit tmo;
        logic [7:0] exp2;
`ifdef ADC_SCAN_AVG_EN
        exp2 = 8'h89;
`else
        exp2 = 8'h91;
`endif
        pulse_reset();
        tbl[0] = 8'h80;
        do_scan(n_rv, n_done, c_first, c_last, c_done, n_oe, order, tmo);
        rd_ch = 3'd0; #1;
        checks++;
        if (tmo || rd_data !== 8'h80) begin
            errors++;
            $display("FAIL avg_first got tmo=%0d bank0=%h want 0/80", tmo, rd_data);
        end
        tbl[0] = 8'h91;
        do_scan(n_rv, n_done, c_first, c_last, c_done, n_oe, order, tmo);
        rd_ch = 3'd0; #1;
        checks++;
        if (tmo || rd_data !== exp2) begin
            errors++;
            $display("FAIL avg_second got tmo=%0d bank0=%h want 0/%h", tmo, rd_data, exp2);
        end
    endtask

    initial begin
        res_n = 1'b0; run = 1'b0; single = 1'b0; run_m = 1'b0; rd_ch = 3'd0;
        load_table();
        test_reset();
        test_single_scan();
        test_timeout();
        test_run_mask();
        test_reset_mid();
        test_single_busy();
        test_avg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
